// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM state constants.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_XOR  = 3'b001,
        OP_NAND = 3'b010,
        OP_SUB  = 3'b011,
        OP_MUL  = 3'b100,
        OP_ACC  = 3'b101,
        OP_LDA  = 3'b110,
        OP_ILL  = 3'b111
    } opcode_e;

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t BUSY = 1'b1;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier core: one partial-product step per clock, WIDTH steps per product.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    // product is the running sum including the current step, so it is final when done is high
    assign addend  = mplier[0] ? mcand : '0;
    assign product = partial + addend;
    assign done    = (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            partial <= '0;
            mplier  <= '0;
            cnt     <= '0;
        end else if (start) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            partial <= '0;
            mplier  <= b;
            cnt     <= CNT_W'(WIDTH);
        end else if (cnt != '0) begin
            partial <= product;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes, accumulator, flags and a multi-cycle multiplier.
//   state | meaning
//   IDLE  | accepting operands; single-cycle ops complete here
//   BUSY  | multiply in progress, input stalled
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic               in_accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     sum_ab;
    logic [WIDTH:0]     diff_ab;
    logic [WIDTH:0]     sum_acc;
    logic [WIDTH-1:0]   res_out;
    logic               res_carry;
    logic               res_err;

    assign in_ready  = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign in_accept = in_valid && in_ready;
    assign mul_start = in_accept && (opcode == OP_MUL);

    // the extra top bit of the difference is the borrow
    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign diff_ab = {1'b0, a} - {1'b0, b};
    assign sum_acc = {1'b0, acc} + {1'b0, a};

    always_comb begin
        res_out   = '0;
        res_carry = 1'b0;
        res_err   = 1'b0;
        case (opcode)
            OP_ADD:  {res_carry, res_out} = sum_ab;
            OP_XOR:  res_out = a ^ b;
            OP_NAND: res_out = ~(a & b);
            OP_SUB:  {res_carry, res_out} = diff_ab;
            OP_ACC:  {res_carry, res_out} = sum_acc;
            OP_LDA:  res_out = a;
            OP_MUL:  res_out = '0;
            default: res_err = 1'b1;
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            out       <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (state == IDLE) begin
                if (mul_start) begin
                    state <= BUSY;
                end else if (in_accept) begin
                    out       <= res_out;
                    carry     <= res_carry;
                    zero      <= (res_out == '0);
                    err       <= res_err;
                    out_valid <= 1'b1;
                    if (opcode == OP_ACC) begin
                        acc <= sum_acc[WIDTH-1:0];
                    end else if (opcode == OP_LDA) begin
                        acc <= a;
                    end
                end
            end else if (mul_done) begin
                out       <= mul_product[WIDTH-1:0];
                carry     <= |mul_product[2*WIDTH-1:WIDTH];
                zero      <= (mul_product[WIDTH-1:0] == '0);
                err       <= 1'b0;
                out_valid <= 1'b1;
                state     <= IDLE;
            end
        end
    end

endmodule
